// File: rtl/secuenciador_ciclo_bus.sv
// Multiplexed A/D bus cycle sequencer toward the RTC chip.
// Phase count c_5 feeds the downstream read/write index counters.
module secuenciador_ciclo_bus #(
  parameter int HOLD = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       W_R,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ale,
  output logic [3:0] c_5,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       done
);

  localparam logic [3:0] LAST = 4'(HOLD - 1);

  logic [3:0] r_c5;
  logic [3:0] r_hold;
  logic       r_rd;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;

  logic [3:0] w_c5_nx;
  logic [3:0] w_hold_nx;
  logic       w_last;
  logic       w_start;

  assign w_last  = (r_hold == LAST);
  // a start happens from idle or chained off the last recovery clock
  assign w_start = en && ((r_c5 == 4'd0) ||
                          (r_c5 == 4'd9 && w_last));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c5    <= 4'd0;
      r_hold  <= 4'd0;
      r_rd    <= 1'b0;
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
    end else begin
      r_c5   <= w_c5_nx;
      r_hold <= w_hold_nx;
      if (w_start) begin
        r_rd    <= W_R;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      if (r_rd && r_c5 == 4'd7 && w_last)
        r_rdata <= ad_in;
    end
  end

  always_comb begin
    w_c5_nx   = r_c5;
    w_hold_nx = r_hold;
    case (r_c5)
      4'd0: begin
        if (en) begin
          w_c5_nx   = 4'd1;
          w_hold_nx = 4'd0;
        end
      end
      4'd4: begin
        w_c5_nx   = 4'd5;
        w_hold_nx = 4'd0;
      end
      4'd1, 4'd2, 4'd3, 4'd5,
      4'd6, 4'd7, 4'd8, 4'd9: begin
        if (w_last) begin
          w_hold_nx = 4'd0;
          if (r_c5 == 4'd9)
            w_c5_nx = en ? 4'd1 : 4'd0;
          else
            w_c5_nx = 4'(r_c5 + 4'd1);
        end else begin
          w_hold_nx = 4'(r_hold + 4'd1);
        end
      end
      default: begin
        w_c5_nx   = 4'd0;
        w_hold_nx = 4'd0;
      end
    endcase
  end

  always_comb begin
    cs_n   = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    ale    = 1'b1;
    ad_oe  = 1'b0;
    ad_out = 8'h00;
    case (r_c5)
      4'd1, 4'd2, 4'd3: begin
        cs_n   = 1'b0;
        ale    = 1'b0;
        ad_oe  = 1'b1;
        ad_out = r_addr;
        wr_n   = (r_c5 != 4'd2);
      end
      4'd5, 4'd6, 4'd7, 4'd8: begin
        cs_n = 1'b0;
        if (r_rd) begin
          rd_n = !(r_c5 == 4'd6 || r_c5 == 4'd7);
        end else begin
          ad_oe  = 1'b1;
          ad_out = r_wdata;
          wr_n   = !(r_c5 == 4'd6 || r_c5 == 4'd7);
        end
      end
      default: ;
    endcase
  end

  assign c_5         = r_c5;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rd && (r_c5 == 4'd8) && (r_hold == 4'd0);
  assign done        = (r_c5 == 4'd9) && w_last;

endmodule

// File: tb/tb_secuenciador_ciclo_bus.sv
// Bench for secuenciador_ciclo_bus: offset-based transaction model
// with directed scenarios and a randomized soak.
module tb_secuenciador_ciclo_bus;

  localparam int H = 3;
  localparam int L = 8 * H + 1;

  logic       clk = 1'b0;
  logic       rst, en, W_R;
  logic [7:0] addr, wdata, ad_in;
  logic [7:0] ad_out, rdata;
  logic       ad_oe, cs_n, rd_n, wr_n, ale, rdata_valid, done;
  logic [3:0] c_5;

  int errors = 0;
  int checks = 0;

  secuenciador_ciclo_bus #(.HOLD(H)) dut (
    .clk(clk), .rst(rst), .en(en), .W_R(W_R),
    .addr(addr), .wdata(wdata), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n),
    .rd_n(rd_n), .wr_n(wr_n), .ale(ale), .c_5(c_5),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: clock offset within the transaction (0 = idle, 1..L)
  int         m_off = 0;
  bit         m_rd = 0;
  logic [7:0] m_a = 0, m_wd = 0, m_rdata = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_off <= 0; m_rd <= 0; m_a <= 0; m_wd <= 0; m_rdata <= 0;
    end else begin
      if (m_rd && m_off == 6 * H + 1) m_rdata <= ad_in;
      if ((m_off == 0 || m_off == L) && en) begin
        m_off <= 1; m_rd <= W_R; m_a <= addr; m_wd <= wdata;
      end else if (m_off == L) m_off <= 0;
      else if (m_off != 0) m_off <= m_off + 1;
    end
  end

  function automatic logic [18:0] exp_bus(int off, bit rd,
                                          logic [7:0] a, logic [7:0] wd);
    int ph;
    logic cs, rn, wn, al, oe, rv, dn;
    logic [7:0] o;
    if (off == 0) ph = 0;
    else if (off <= 3 * H) ph = (off - 1) / H + 1;
    else if (off == 3 * H + 1) ph = 4;
    else ph = (off - 3 * H - 2) / H + 5;
    cs = 1; rn = 1; wn = 1; al = 1; oe = 0; o = 8'h00;
    if (ph >= 1 && ph <= 3) begin
      cs = 0; al = 0; oe = 1; o = a; wn = (ph != 2);
    end else if (ph >= 5 && ph <= 8) begin
      cs = 0;
      if (rd) rn = !(ph == 6 || ph == 7);
      else begin
        oe = 1; o = wd; wn = !(ph == 6 || ph == 7);
      end
    end
    rv = rd && (off == 6 * H + 2);
    dn = (off == L);
    return {4'(ph), cs, rn, wn, al, oe, o, rv, dn};
  endfunction

  logic [18:0] w_dut, w_exp;
  assign w_dut = {c_5, cs_n, rd_n, wr_n, ale, ad_oe, ad_out, rdata_valid, done};
  always_comb w_exp = exp_bus(m_off, m_rd, m_a, m_wd);

  function automatic logic [7:0] not_a7();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (v == 8'hA7) v = 8'h5A;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1; en = 1; W_R = 1'($urandom);
    addr = 8'($urandom); wdata = 8'($urandom); ad_in = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({c_5, cs_n, rd_n, wr_n, ale, ad_oe, rdata, rdata_valid, done}
          !== {4'd0, 5'b11110, 8'h00, 2'b00}) begin
        errors++;
        $display("FAIL reset_idle i=%0d got c5=%0d cs=%b rd=%b wr=%b ale=%b oe=%b rdata=%h rv=%b dn=%b exp idle",
                 i, c_5, cs_n, rd_n, wr_n, ale, ad_oe, rdata, rdata_valid, done);
      end
      en = 1; addr = 8'($urandom);
    end
    rst = 0; en = 0;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    en = 1; W_R = 1; addr = 8'h05; wdata = 8'($urandom); ad_in = not_a7();
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      en = 0;
      checks++;
      if (w_dut !== w_exp || rdata !== m_rdata) begin
        errors++;
        $display("FAIL rd_model k=%0d got=%h/%h exp=%h/%h", k, w_dut, rdata, w_exp, m_rdata);
      end
      checks++;
      if (rd_n !== !(k >= 14 && k <= 19)) begin
        errors++; $display("FAIL rd_strobe k=%0d got=%b", k, rd_n);
      end
      checks++;
      if (wr_n !== !(k >= 4 && k <= 6)) begin
        errors++; $display("FAIL rd_addr_strobe k=%0d got=%b", k, wr_n);
      end
      checks++;
      if (rdata_valid !== (k == 20) || done !== (k == 25)) begin
        errors++;
        $display("FAIL rd_pulses k=%0d got rv=%b done=%b", k, rdata_valid, done);
      end
      if (k >= 20) begin
        checks++;
        if (rdata !== 8'hA7) begin
          errors++; $display("FAIL rd_data k=%0d got=%h exp=a7", k, rdata);
        end
      end
      if (k == 26) begin
        checks++;
        if (c_5 !== 4'd0) begin
          errors++; $display("FAIL rd_end k=%0d got c5=%0d exp 0", k, c_5);
        end
      end
      addr = 8'($urandom); W_R = 1'($urandom);
      ad_in = (k == 19) ? 8'hA7 : not_a7();
    end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    en = 1; W_R = 0; addr = 8'h21; wdata = 8'h3C;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      en = 0;
      checks++;
      if (w_dut !== w_exp || rdata !== m_rdata) begin
        errors++;
        $display("FAIL wr_model k=%0d got=%h/%h exp=%h/%h", k, w_dut, rdata, w_exp, m_rdata);
      end
      if (k <= 9) begin
        checks++;
        if (ad_out !== 8'h21 || ad_oe !== 1'b1) begin
          errors++; $display("FAIL wr_addr k=%0d got=%h oe=%b exp 21", k, ad_out, ad_oe);
        end
      end
      if (k >= 11 && k <= 22) begin
        checks++;
        if (ad_out !== 8'h3C || ad_oe !== 1'b1) begin
          errors++; $display("FAIL wr_data k=%0d got=%h oe=%b exp 3c", k, ad_out, ad_oe);
        end
      end
      checks++;
      if (wr_n !== !((k >= 4 && k <= 6) || (k >= 14 && k <= 19))) begin
        errors++; $display("FAIL wr_strobe k=%0d got=%b", k, wr_n);
      end
      checks++;
      if (rdata_valid !== 1'b0) begin
        errors++; $display("FAIL wr_no_rv k=%0d got=%b exp 0", k, rdata_valid);
      end
      addr = 8'($urandom); wdata = 8'($urandom); W_R = 1'($urandom);
      ad_in = 8'($urandom);
    end
  endtask

  task automatic test_continuous();
    int nd = 0, n4 = 0, last4 = -1, cyc = 0;
    bit gap = 0;
    @(negedge clk);
    en = 1; W_R = 1; addr = 8'($urandom); ad_in = 8'($urandom);
    while (nd < 18 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (w_dut !== w_exp || rdata !== m_rdata) begin
        errors++;
        $display("FAIL cont_model cyc=%0d got=%h/%h exp=%h/%h", cyc, w_dut, rdata, w_exp, m_rdata);
      end
      if (c_5 == 4'd0) gap = 1;
      if (c_5 == 4'd4) begin
        n4++;
        if (last4 >= 0) begin
          checks++;
          if (cyc - last4 != L) begin
            errors++; $display("FAIL cont_spacing got=%0d exp=%0d", cyc - last4, L);
          end
        end
        last4 = cyc;
      end
      if (done === 1'b1) nd++;
      en = (nd < 18);
      W_R = ($urandom_range(0, 3) != 0);
      addr = 8'($urandom); wdata = 8'($urandom); ad_in = 8'($urandom);
    end
    checks++;
    if (nd != 18 || n4 != 18) begin
      errors++; $display("FAIL cont_counts done=%0d c5_4=%0d exp 18/18", nd, n4);
    end
    checks++;
    if (gap) begin
      errors++; $display("FAIL cont_gap got idle clock exp none");
    end
    @(negedge clk);
    checks++;
    if (c_5 !== 4'd0) begin
      errors++; $display("FAIL cont_end got c5=%0d exp 0", c_5);
    end
  endtask

  task automatic test_en_drop();
    @(negedge clk);
    en = 1; W_R = 1; addr = 8'($urandom); ad_in = 8'($urandom);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      checks++;
      if (w_dut !== w_exp || rdata !== m_rdata) begin
        errors++;
        $display("FAIL drop_model k=%0d got=%h/%h exp=%h/%h", k, w_dut, rdata, w_exp, m_rdata);
      end
      checks++;
      if (rd_n !== !(k >= 14 && k <= 19) || wr_n !== !(k >= 4 && k <= 6)) begin
        errors++; $display("FAIL drop_dir k=%0d got rd=%b wr=%b", k, rd_n, wr_n);
      end
      checks++;
      if (done !== (k == 25)) begin
        errors++; $display("FAIL drop_done k=%0d got=%b", k, done);
      end
      if (k >= 26) begin
        checks++;
        if (c_5 !== 4'd0) begin
          errors++; $display("FAIL drop_idle k=%0d got c5=%0d exp 0", k, c_5);
        end
      end
      if (k == 7) W_R = 0;
      if (k >= 14) en = 0;
      ad_in = 8'($urandom);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    en = 1; W_R = 1; addr = 8'($urandom); ad_in = 8'($urandom);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      en = 0;
      if (k == 18) begin
        checks++;
        if ({c_5, cs_n, rd_n, wr_n, ale, ad_oe, ad_out, rdata}
            !== {4'd0, 5'b11110, 8'h00, 8'h00}) begin
          errors++;
          $display("FAIL rstmid_idle got c5=%0d cs=%b rd=%b wr=%b ale=%b oe=%b out=%h rdata=%h",
                   c_5, cs_n, rd_n, wr_n, ale, ad_oe, ad_out, rdata);
        end
      end
      if (k >= 18) begin
        checks++;
        if (rdata_valid !== 1'b0 || done !== 1'b0) begin
          errors++; $display("FAIL rstmid_pulse k=%0d got rv=%b done=%b exp 0", k, rdata_valid, done);
        end
      end
      rst = (k == 17);
      ad_in = 8'($urandom);
    end
    en = 1; W_R = 1; addr = 8'($urandom);
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      en = 0;
      checks++;
      if (w_dut !== w_exp || rdata !== m_rdata) begin
        errors++;
        $display("FAIL rstmid_model k=%0d got=%h/%h exp=%h/%h", k, w_dut, rdata, w_exp, m_rdata);
      end
      checks++;
      if (rdata_valid !== (k == 20) || done !== (k == 25)) begin
        errors++; $display("FAIL rstmid_restart k=%0d got rv=%b done=%b", k, rdata_valid, done);
      end
      ad_in = 8'($urandom);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++;
      if (w_dut !== w_exp || rdata !== m_rdata || c_5 > 4'd9) begin
        errors++;
        $display("FAIL rand_model i=%0d got=%h/%h exp=%h/%h", i, w_dut, rdata, w_exp, m_rdata);
      end
      rst = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 3) != 0);
      W_R = 1'($urandom);
      addr = 8'($urandom); wdata = 8'($urandom); ad_in = 8'($urandom);
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_continuous();
    test_en_drop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
